// File: rtl/ad9268_pkg.sv
// Shared types and sizing for the AD9268 triggered capture block.
package ad9268_pkg;

  // Capture sequencer states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_WAIT_TRIG,
    ST_POST,
    ST_DONE
  } cap_state_t;

  // Number of sample pairs held by a buffer with the given address width
  function automatic int unsigned ad9268_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/ad9268_trig_capture_dpram_1clk.sv
// Simple dual-port RAM on one clock: one write port, one registered read port.
// Contents are never reset.
module dpram_1clk #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rdata;

  // Write port
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read port, one cycle of latency
  always_ff @(posedge i_clk) begin
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ad9268_trig_capture.sv
// AD9268 triggered capture: circular pre-trigger buffer of {A,B} sample pairs,
// rising-edge threshold trigger on channel A (or forced), then a post-trigger
// fill that completes the buffer. Readout is relative to the oldest sample.
// Optional decimation is enabled with the macro AD9268_CAPTURE_DECIM_EN.
module ad9268_trig_capture
  import ad9268_pkg::*;
#(
  parameter int ADC_DATA_WIDTH = 16,
  parameter int AW             = 10
) (
  input  logic                          adc_clk,
  input  logic                          rst,
  input  logic [ADC_DATA_WIDTH-1:0]     data_a,
  input  logic [ADC_DATA_WIDTH-1:0]     data_b,
  input  logic                          arm,
  input  logic                          force_trig,
  input  logic [ADC_DATA_WIDTH-1:0]     threshold,
  input  logic [AW-1:0]                 pretrig,
  input  logic [AW-1:0]                 rd_addr,
`ifdef AD9268_CAPTURE_DECIM_EN
  input  logic [7:0]                    decim,
`endif
  output logic [2*ADC_DATA_WIDTH-1:0]   rd_data,
  output logic                          busy,
  output logic                          done,
  output logic [AW-1:0]                 trig_index
);

  localparam int          DEPTH    = ad9268_depth(AW);
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_MAX   = {1'b0, {AW{1'b1}}};
  localparam logic [AW:0] LP_ONE   = (AW+1)'(1);

  cap_state_t r_state, w_state_nxt;

  logic signed [ADC_DATA_WIDTH-1:0] r_a_q, r_prev_a, r_thr;
  logic        [ADC_DATA_WIDTH-1:0] r_b_q;
  logic [AW-1:0] r_pre, r_wr_ptr, r_trig_ptr, r_base, r_trig_index;
  logic [AW:0]   r_cnt, w_cnt_nxt, w_cnt_inc, w_post_len;
  logic [AW-1:0] w_pre_clamp, w_trig_addr, w_rd_addr;
  logic          w_tick, w_trig_hit, w_wr_en, w_trig_cap, w_enter_done;

  // Pretrig larger than the buffer can hold is limited to DEPTH-1 so at
  // least the trigger sample itself lands in the post section.
  assign w_pre_clamp = ({1'b0, pretrig} > LP_MAX) ? LP_MAX[AW-1:0] : pretrig;
  assign w_post_len  = LP_DEPTH - {1'b0, r_pre};
  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_trig_hit  = (r_prev_a < r_thr) && (r_a_q >= r_thr);

`ifdef AD9268_CAPTURE_DECIM_EN
  logic [7:0] r_dcnt;

  // Decimation phase counter; restarted by arm so the first sample after arm is kept
  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst)                         r_dcnt <= '0;
    else if (arm || r_dcnt >= decim) r_dcnt <= '0;
    else                             r_dcnt <= r_dcnt + 1'b1;
  end

  assign w_tick = (r_dcnt == '0);
`else
  assign w_tick = 1'b1;
`endif

  // Next state, write enable and sample count; arm overrides everything
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_wr_en      = 1'b0;
    w_trig_cap   = 1'b0;
    w_enter_done = 1'b0;
    if (arm) begin
      w_cnt_nxt   = '0;
      w_state_nxt = (w_pre_clamp == '0) ? ST_WAIT_TRIG : ST_PRE;
    end else if (w_tick) begin
      case (r_state)
        ST_PRE: begin
          w_wr_en   = 1'b1;
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == {1'b0, r_pre}) w_state_nxt = ST_WAIT_TRIG;
        end
        ST_WAIT_TRIG: begin
          // Buffer keeps rolling here, so the newest r_pre samples are always held
          w_wr_en = 1'b1;
          if (w_trig_hit || force_trig) begin
            w_trig_cap = 1'b1;
            w_cnt_nxt  = LP_ONE;
            if (w_post_len == LP_ONE) begin
              w_state_nxt  = ST_DONE;
              w_enter_done = 1'b1;
            end else begin
              w_state_nxt = ST_POST;
            end
          end
        end
        ST_POST: begin
          w_wr_en   = 1'b1;
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == w_post_len) begin
            w_state_nxt  = ST_DONE;
            w_enter_done = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State and sample counter
  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Input sample register and trigger history (history advances per kept sample)
  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst) begin
      r_a_q    <= '0;
      r_b_q    <= '0;
      r_prev_a <= '0;
    end else begin
      r_a_q <= data_a;
      r_b_q <= data_b;
      if (w_tick) r_prev_a <= r_a_q;
    end
  end

  // Capture parameters latched at arm
  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
      r_thr <= '0;
    end else if (arm) begin
      r_pre <= w_pre_clamp;
      r_thr <= threshold;
    end
  end

  // Write pointer, trigger address and readout base
  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_trig_ptr   <= '0;
      r_base       <= '0;
      r_trig_index <= '0;
    end else begin
      if (w_wr_en)    r_wr_ptr   <= r_wr_ptr + 1'b1;
      if (w_trig_cap) r_trig_ptr <= r_wr_ptr;
      if (w_enter_done) begin
        r_base       <= w_trig_addr - r_pre;
        r_trig_index <= r_pre;
      end
    end
  end

  // When the trigger sample is also the last one, its address is still r_wr_ptr
  assign w_trig_addr = w_trig_cap ? r_wr_ptr : r_trig_ptr;
  assign w_rd_addr   = r_base + rd_addr;

  dpram_1clk #(
    .DW(2*ADC_DATA_WIDTH),
    .AW(AW)
  ) u_mem (
    .i_clk  (adc_clk),
    .i_we   (w_wr_en),
    .i_waddr(r_wr_ptr),
    .i_wdata({r_a_q, r_b_q}),
    .i_raddr(w_rd_addr),
    .o_rdata(rd_data)
  );

  assign busy       = (r_state == ST_PRE) || (r_state == ST_WAIT_TRIG) || (r_state == ST_POST);
  assign done       = (r_state == ST_DONE);
  assign trig_index = r_trig_index;

endmodule

// File: tb/tb_ad9268_trig_capture.sv
// Directed bench for ad9268_trig_capture (AW=10, 16-bit samples).
// Sample n is driven for the edge that advances n to n+1; B always carries n
// so readout positions can be checked by hand.
module tb_ad9268_trig_capture;

  localparam int DW = 16;
  localparam int AW = 10;

  logic          adc_clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_a, data_b, threshold;
  logic          arm, force_trig;
  logic [AW-1:0] pretrig, rd_addr, trig_index;
  logic [2*DW-1:0] rd_data;
  logic          busy, done;
`ifdef AD9268_CAPTURE_DECIM_EN
  logic [7:0]    decim;
`endif

  int n, mode, errs, checks;

  always #5 adc_clk = ~adc_clk;

  ad9268_trig_capture #(.ADC_DATA_WIDTH(DW), .AW(AW)) dut (
    .adc_clk   (adc_clk),
    .rst       (rst),
    .data_a    (data_a),
    .data_b    (data_b),
    .arm       (arm),
    .force_trig(force_trig),
    .threshold (threshold),
    .pretrig   (pretrig),
    .rd_addr   (rd_addr),
`ifdef AD9268_CAPTURE_DECIM_EN
    .decim     (decim),
`endif
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .trig_index(trig_index)
  );

  function automatic logic [DW-1:0] gen_a(input int m, input int k);
    case (m)
      1:       return 16'(k - 500);
      2:       return ((k >= 100 && k < 150) || k >= 400) ? 16'(1000) : 16'(-1000);
      5:       return (k >= 20) ? 16'(1000) : 16'(-1000);
      default: return '0;
    endcase
  endfunction

  function automatic logic [31:0] pk(input int a, input int b);
    return {16'(a), 16'(b)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge adc_clk);
    #1;
    n++;
    data_a = gen_a(mode, n);
    data_b = 16'(n);
  endtask

  task automatic run_to(input int target);
    while (n < target) step();
  endtask

  task automatic start(input int m, input int pt, input int thr);
    mode      = m;
    n         = 0;
    data_a    = gen_a(m, 0);
    data_b    = '0;
    pretrig   = AW'(pt);
    threshold = 16'(thr);
    arm       = 1'b1;
    step();
    arm       = 1'b0;
  endtask

  task automatic pulse_force();
    force_trig = 1'b1;
    step();
    force_trig = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_n);
    int lim;
    lim = 0;
    while (!done && lim < 5000) begin
      step();
      lim++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_n"}, n, exp_n);
  endtask

  task automatic rd(input string tag, input int addr, input logic [31:0] exp);
    rd_addr = AW'(addr);
    step();
    chk(tag, rd_data, exp);
  endtask

  initial begin
    errs = 0; checks = 0; n = 0; mode = 0;
    rst = 1'b1; arm = 1'b0; force_trig = 1'b0;
    data_a = '0; data_b = '0; threshold = '0; pretrig = '0; rd_addr = '0;
`ifdef AD9268_CAPTURE_DECIM_EN
    decim = '0;
`endif
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tidx", trig_index, 0);
    rst = 1'b0;
    repeat (3) step();

    // Ramp through thr=100 with no pretrigger: trigger sample is A=100 (n=600)
    start(1, 0, 100);
    chk("t1_busy", busy, 1);
    wait_done("t1", 600 + 1 + 1024);
    chk("t1_tidx", trig_index, 0);
    chk("t1_busy_end", busy, 0);
    rd("t1_rd0", 0, pk(100, 600));
    rd("t1_rd1023", 1023, pk(1123, 1623));

    // First crossing (n=100) falls in PRE and is ignored; second at n=400 triggers
    start(2, 256, 0);
    wait_done("t2", 400 + 1 + 768);
    chk("t2_tidx", trig_index, 256);
    rd("t2_rd256", 256, pk(1000, 400));
    rd("t2_rd255", 255, pk(-1000, 399));
    rd("t2_rd0", 0, pk(1000, 144));

    // Unreachable threshold; force in PRE ignored, force at n=2000 after wrap
    start(3, 100, 32767);
    run_to(50);
    pulse_force();
    run_to(2000);
    pulse_force();
    wait_done("t3", 1999 + 1 + 924);
    chk("t3_tidx", trig_index, 100);
    rd("t3_rd100", 100, pk(0, 1999));
    rd("t3_rd0", 0, pk(0, 1899));
    rd("t3_rd1023", 1023, pk(0, 2922));

    // Re-arm 50 cycles into POST with a new pretrig; only the new capture completes
    start(3, 16, 32767);
    run_to(30);
    pulse_force();
    run_to(80);
    pretrig = AW'(32);
    arm = 1'b1;
    step();
    arm = 1'b0;
    run_to(200);
    pulse_force();
    run_to(1100);
    chk("t4_busy_mid", busy, 1);
    chk("t4_done_mid", done, 0);
    wait_done("t4", 199 + 1 + 992);
    chk("t4_tidx", trig_index, 32);
    rd("t4_rd32", 32, pk(0, 199));
    rd("t4_rd0", 0, pk(0, 167));

    // Arm and force on the same cycle in WAIT_TRIG: arm wins, capture restarts
    start(3, 8, 32767);
    run_to(20);
    arm = 1'b1;
    force_trig = 1'b1;
    step();
    arm = 1'b0;
    force_trig = 1'b0;
    chk("t6_busy", busy, 1);
    run_to(100);
    pulse_force();
    wait_done("t6", 99 + 1 + 1016);
    chk("t6_tidx", trig_index, 8);
    rd("t6_rd8", 8, pk(0, 99));

    // Reset while waiting for a trigger; a later crossing must do nothing
    start(5, 0, 100);
    run_to(10);
    chk("t5_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_tidx", trig_index, 0);
    step();
    rst = 1'b0;
    run_to(1200);
    chk("t5_busy_end", busy, 0);
    chk("t5_done_end", done, 0);

`ifdef AD9268_CAPTURE_DECIM_EN
    // Keep every 4th sample; trigger on sample 0, 1024 kept samples span 4093 edges
    decim = 8'd3;
    start(3, 0, 32767);
    pulse_force();
    wait_done("td", 4094);
    rd("td_rd0", 0, pk(0, 0));
    rd("td_rd1", 1, pk(0, 4));
    rd("td_rd1023", 1023, pk(0, 4092));
    decim = 8'd0;
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
